// File: rtl/xmit_pkg.sv
// Shared types and helpers for the transmit output path.
//   xmit_state_e  : FSM state encoding (IDLE, PRE, SFD, DATA, IFG)
//   ctrl_w()      : control block width from the length and sequence field widths
//   preamble_sym(): repeating 2'b01 symbol of the given width (LSB set)
//   sfd_sym()     : preamble symbol with its MSB also set
package xmit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
        StIfg
    } xmit_state_e;

    // Widest PHY symbol the helper functions can build.
    localparam int unsigned SymMaxW = 64;

    function automatic int unsigned ctrl_w(input int unsigned len_w, input int unsigned seq_w);
        return len_w + seq_w;
    endfunction

    function automatic logic [SymMaxW-1:0] preamble_sym(input int unsigned phy_w);
        logic [SymMaxW-1:0] sym;
        sym = '0;
        for (int unsigned i = 0; i < phy_w; i += 2) begin
            sym = sym | (SymMaxW'(1) << i);
        end
        return sym;
    endfunction

    function automatic logic [SymMaxW-1:0] sfd_sym(input int unsigned phy_w);
        return preamble_sym(phy_w) | (SymMaxW'(1) << (phy_w - 1));
    endfunction

endpackage

// File: rtl/xmit_piso.sv
// Word-to-symbol shift register.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   load_i  : data_i is present; its low symbol is passed straight through to sym_o
//             and the remaining symbols are stored
//   shift_i : emit the next stored symbol and advance
//   data_i  : DATA_W-bit word
//   sym_o   : current PHY_W-bit symbol, LSB symbol first
module xmit_piso #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PHY_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [PHY_W-1:0]  sym_o
);

    logic [DATA_W-1:0] sreg_q;

    // Bypass on load so the first symbol leaves in the same cycle the word arrives.
    assign sym_o = load_i ? data_i[PHY_W-1:0] : sreg_q[PHY_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i >> PHY_W;
        end else if (shift_i) begin
            sreg_q <= sreg_q >> PHY_W;
        end
    end

endmodule

// File: rtl/xmit_out_fsm_param.sv
// Transmit output FSM: takes one control block per frame, pops the frame words from the
// upstream buffer and sends preamble, SFD, data (LSB symbol first) and an inter-frame gap.
//   clk_phy       : PHY clock
//   reset         : synchronous, active-high
//   ctrl_valid    : ctrl_block_in valid
//   ctrl_ready    : control block accepted (IDLE only)
//   ctrl_block_in : {sequence, length-in-words}
//   rd_en         : pop one buffer word; data_in valid the following cycle
//   data_in       : buffer read data
//   tx_en         : PHY transmit enable (registered)
//   data_out      : PHY symbol (registered), 0 while tx_en is low
//   frame_seq_out : sequence number of the last accepted frame
//   xmit_done_out : one-cycle pulse at frame completion
module xmit_out_fsm_param
    import xmit_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned PHY_W         = 4,
    parameter int unsigned LEN_W         = 12,
    parameter int unsigned SEQ_W         = 12,
    parameter int unsigned PREAMBLE_SYMS = 15,
    parameter int unsigned IFG_SYMS      = 24,
    localparam int unsigned CTRL_W       = ctrl_w(LEN_W, SEQ_W)
) (
    input  logic              clk_phy,
    input  logic              reset,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [CTRL_W-1:0] ctrl_block_in,
    output logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_en,
    output logic [PHY_W-1:0]  data_out,
    output logic [SEQ_W-1:0]  frame_seq_out,
    output logic              xmit_done_out
);

    localparam int unsigned Syms    = DATA_W / PHY_W;
    localparam int unsigned SymCntW = (Syms > 1) ? $clog2(Syms) : 1;
    localparam int unsigned PreCntW = $clog2(PREAMBLE_SYMS + 1);
    localparam int unsigned IfgCntW = $clog2(IFG_SYMS + 1);

    localparam logic [PHY_W-1:0] PreSym = PHY_W'(preamble_sym(PHY_W));
    localparam logic [PHY_W-1:0] SfdSym = PHY_W'(sfd_sym(PHY_W));

    xmit_state_e        state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [PreCntW-1:0] pre_cnt_q, pre_cnt_d;
    logic [SymCntW-1:0] sym_cnt_q, sym_cnt_d;
    logic [IfgCntW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic               tx_en_q, tx_en_d;
    logic [PHY_W-1:0]   data_out_q, data_out_d;
    logic               done_q, done_d;

    logic               accept, rd_req, last_sym, last_word;
    logic               piso_load, piso_shift;
    logic [PHY_W-1:0]   piso_sym;

    assign ctrl_ready = (state_q == StIdle) && !reset;
    assign accept     = ctrl_valid && ctrl_ready;
    assign last_sym   = (sym_cnt_q == SymCntW'(Syms - 1));
    assign last_word  = (word_cnt_q == len_q - LEN_W'(1));
    assign rd_en      = rd_req && !reset;

    xmit_piso #(
        .DATA_W(DATA_W),
        .PHY_W (PHY_W)
    ) u_piso (
        .clk_i  (clk_phy),
        .rst_i  (reset),
        .load_i (piso_load),
        .shift_i(piso_shift),
        .data_i (data_in),
        .sym_o  (piso_sym)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        seq_d      = seq_q;
        word_cnt_d = word_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        tx_en_d    = 1'b0;
        data_out_d = '0;
        done_d     = 1'b0;
        rd_req     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    len_d     = ctrl_block_in[LEN_W-1:0];
                    seq_d     = ctrl_block_in[CTRL_W-1:LEN_W];
                    pre_cnt_d = '0;
                    if (ctrl_block_in[LEN_W-1:0] == '0) begin
                        // Empty frame: done right away, then a gap one cycle
                        // shorter in state terms since the pulse leads the gap.
                        state_d   = StIfg;
                        ifg_cnt_d = IfgCntW'(IFG_SYMS - 1);
                        done_d    = 1'b1;
                    end else begin
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                tx_en_d    = 1'b1;
                data_out_d = PreSym;
                if (pre_cnt_q == PreCntW'(PREAMBLE_SYMS - 1)) begin
                    state_d = StSfd;
                end else begin
                    pre_cnt_d = pre_cnt_q + PreCntW'(1);
                end
            end
            StSfd: begin
                tx_en_d    = 1'b1;
                data_out_d = SfdSym;
                rd_req     = 1'b1;
                state_d    = StData;
                sym_cnt_d  = '0;
                word_cnt_d = '0;
            end
            StData: begin
                tx_en_d    = 1'b1;
                data_out_d = piso_sym;
                piso_load  = (sym_cnt_q == '0);
                piso_shift = !piso_load;
                if (last_sym) begin
                    sym_cnt_d = '0;
                    if (last_word) begin
                        // One extra IFG state cycle covers the tx_en fall before done.
                        state_d   = StIfg;
                        ifg_cnt_d = IfgCntW'(IFG_SYMS);
                    end else begin
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        rd_req     = 1'b1;
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + SymCntW'(1);
                end
            end
            StIfg: begin
                // Only a data frame loads the full IFG_SYMS count.
                done_d = (ifg_cnt_q == IfgCntW'(IFG_SYMS));
                if (ifg_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - IfgCntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            seq_q      <= '0;
            word_cnt_q <= '0;
            pre_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            ifg_cnt_q  <= '0;
            tx_en_q    <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            seq_q      <= seq_d;
            word_cnt_q <= word_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            tx_en_q    <= tx_en_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign tx_en         = tx_en_q;
    assign data_out      = data_out_q;
    assign frame_seq_out = seq_q;
    assign xmit_done_out = done_q;

endmodule
